// File: rtl/periph_responder.sv
// Peripheral-space target for the control unit's load/store path: display, LEDs,
// synchronized buttons with sticky edge flags, and a prescaled countdown timer.
module periph_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned BTN_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [14:0]      addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             ack,
  output logic             err,
  input  logic [BTN_W-1:0] btn_in,
  output logic [15:0]      display_value,
  output logic [3:0]       leds,
  output logic             irq
);

  localparam int unsigned AW        = 15;
  localparam int unsigned DW        = 16;
  localparam int unsigned WCW       = 3;
  localparam int unsigned PW        = $clog2(PRESCALE);
  localparam int unsigned WAIT_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WCW-1:0]   wait_cnt;

  logic [AW-1:0]    lat_addr;
  logic             lat_we;
  logic [DW-1:0]    lat_wdata;

  logic             capture_c;
  logic             enter_ack_c;
  logic             commit_c;

  logic [AW-1:0]    acc_addr;
  logic             acc_hit;
  logic             lat_hit;
  logic [DW-1:0]    rd_mux;

  logic             wr_disp, wr_leds, wr_edge, wr_tctrl, wr_tload, wr_status;

  logic [BTN_W-1:0] btn_meta, btn_sync, btn_prev, btn_edge;
  logic [BTN_W-1:0] btn_rise;

  logic [2:0]       tctrl, tctrl_d;
  logic [DW-1:0]    tload;
  logic [DW-1:0]    tcount, tcount_d;
  logic [PW-1:0]    presc, presc_d;
  logic             expired, expired_d;
  logic             tick;
  logic             exp_set;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (req) next_state = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
      S_WAIT:  if (wait_cnt == WCW'(WAIT_LAST)) next_state = S_ACK;
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Transaction strobes derived from the FSM
  always_comb begin
    capture_c   = 1'b0;
    enter_ack_c = 1'b0;
    commit_c    = 1'b0;
    capture_c   = (state == S_IDLE) && req;
    enter_ack_c = (next_state == S_ACK) && (state != S_ACK);
    commit_c    = (state == S_ACK) && lat_we && lat_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + WCW'(1) : '0;
      if (capture_c) begin
        lat_addr  <= addr;
        lat_we    <= we;
        lat_wdata <= wdata;
      end
    end
  end

  // With no wait states ACK is entered on the capture edge, so read the live address then.
  assign acc_addr = (state == S_IDLE) ? addr : lat_addr;
  assign acc_hit  = (acc_addr[14:3] == '0);
  assign lat_hit  = (lat_addr[14:3] == '0);

  always_comb begin
    rd_mux = '0;
    unique case (acc_addr[2:0])
      3'd0: rd_mux = display_value;
      3'd1: rd_mux = {12'h000, leds};
      3'd2: rd_mux = DW'(btn_sync);
      3'd3: rd_mux = DW'(btn_edge);
      3'd4: rd_mux = {13'h0000, tctrl};
      3'd5: rd_mux = tload;
      3'd6: rd_mux = tcount;
      3'd7: rd_mux = {15'h0000, expired};
      default: rd_mux = '0;
    endcase
  end

  assign wr_disp   = commit_c && (lat_addr[2:0] == 3'd0);
  assign wr_leds   = commit_c && (lat_addr[2:0] == 3'd1);
  assign wr_edge   = commit_c && (lat_addr[2:0] == 3'd3);
  assign wr_tctrl  = commit_c && (lat_addr[2:0] == 3'd4);
  assign wr_tload  = commit_c && (lat_addr[2:0] == 3'd5);
  assign wr_status = commit_c && (lat_addr[2:0] == 3'd7);

  // Response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      ack <= (next_state == S_ACK);
      if (enter_ack_c) begin
        rdata <= acc_hit ? rd_mux : '0;
        err   <= !acc_hit;
      end
    end
  end

  assign btn_rise = btn_sync & ~btn_prev;

  // Button synchronizer and sticky rising-edge flags; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      btn_edge <= '0;
    end else begin
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      btn_edge <= (btn_edge & ~(wr_edge ? BTN_W'(lat_wdata) : '0)) | btn_rise;
    end
  end

  // Timer next-state; a software TCTRL write overrides the hardware enable clear
  always_comb begin
    tick      = tctrl[0] && (presc == PW'(PRESCALE - 1));
    presc_d   = presc;
    tcount_d  = tcount;
    tctrl_d   = tctrl;
    exp_set   = 1'b0;
    if (tctrl[0]) presc_d = tick ? '0 : presc + PW'(1);
    if (tick) begin
      if (tcount != '0) begin
        tcount_d = tcount - DW'(1);
      end else begin
        exp_set = 1'b1;
        if (tctrl[1]) tcount_d = tload;
        else          tctrl_d[0] = 1'b0;
      end
    end
    if (wr_tctrl) begin
      tctrl_d = lat_wdata[2:0];
      if (!tctrl[0] && lat_wdata[0]) begin
        tcount_d = tload;
        presc_d  = '0;
      end
    end
    expired_d = (expired & ~(wr_status & lat_wdata[0])) | exp_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      display_value <= '0;
      leds          <= '0;
      tctrl         <= '0;
      tload         <= '0;
      tcount        <= '0;
      presc         <= '0;
      expired       <= 1'b0;
      irq           <= 1'b0;
    end else begin
      if (wr_disp)  display_value <= lat_wdata;
      if (wr_leds)  leds          <= lat_wdata[3:0];
      if (wr_tload) tload         <= lat_wdata;
      tctrl   <= tctrl_d;
      tcount  <= tcount_d;
      presc   <= presc_d;
      expired <= expired_d;
      irq     <= expired_d & tctrl_d[2];
    end
  end

endmodule
